// File: rtl/apb_fifo_master_if.sv
// -----------------------------------------------------------------------------
// apb_fifo_master_if
// Bundles the three streams seen by apb_fifo_master together with the APB4
// bus it drives.
//   command stream  : cmd_valid/cmd_ready + cmd_write/addr/wdata/strb/len
//   write-data      : wd_valid/wd_ready + wd_data (beats 1..len of a write)
//   response stream : rsp_valid/rsp_ready + rsp_rdata/err/timeout/last
//   APB4            : PADDR PPROT PSEL PENABLE PWRITE PWDATA PSTRB
//                     PREADY PRDATA PSLVERR
// modport master : view of apb_fifo_master (APB requester)
// modport slave  : view of whoever feeds commands and acts as the APB target
// -----------------------------------------------------------------------------
interface apb_fifo_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    localparam int STRB_W = DATA_W / 8;

    // command stream
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;
    logic [LEN_W-1:0]  cmd_len;

    // write-data stream
    logic              wd_valid;
    logic              wd_ready;
    logic [DATA_W-1:0] wd_data;

    // response stream
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              rsp_last;

    // APB4
    logic [ADDR_W-1:0] PADDR;
    logic [2:0]        PPROT;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [STRB_W-1:0] PSTRB;
    logic              PREADY;
    logic [DATA_W-1:0] PRDATA;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_len,
        output cmd_ready,
        input  wd_valid, wd_data,
        output wd_ready,
        input  rsp_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout, rsp_last,
        output PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_len,
        input  cmd_ready,
        output wd_valid, wd_data,
        input  wd_ready,
        output rsp_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout, rsp_last,
        input  PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_fifo_master.sv
// -----------------------------------------------------------------------------
// apb_fifo_master
// APB4 requester for the APB-attached Sync_FIFO (config reg at 0x0000_0000,
// data port at 0x8000_0000). A command describes a fixed-address burst of
// cmd_len+1 beats; each beat is one SETUP + ACCESS pair on APB.
//   Reads  : one response per beat, rsp_last on the final beat. The FSM
//            waits in RESP, so no new SETUP starts while a response is pending.
//   Writes : beat 0 data comes with the command, beats 1..len from the wd
//            stream; one response per burst with PSLVERR OR-ed over all beats.
//   Timeout: TIMEOUT ACCESS cycles with PREADY low abort the burst with a
//            final response flagged rsp_timeout/rsp_err/rsp_last.
// Ports
//   PCLK   : clock, rising edge
//   PRESET : synchronous, active-high reset
//   bus    : command / write-data / response streams and the APB4 bus
// -----------------------------------------------------------------------------
module apb_fifo_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             PCLK,
    input  logic             PRESET,
    apb_fifo_master_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        WDATA,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    // burst context, held for every beat
    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [STRB_W-1:0] pstrb_q;
    logic [LEN_W-1:0]  len_q;

    // one extra bit so cmd_len = all-ones runs 2^LEN_W beats without wrapping
    logic [LEN_W:0]    beat_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              err_acc;

    // response presented in RESP
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;
    logic              rsp_last_q;

    logic cmd_hs;
    logic last_beat;
    logic to_expire;

    assign cmd_hs    = (state == IDLE) && bus.cmd_valid;
    // beat_cnt counts completed beats, so the beat now in flight is the last
    // one when the count equals len
    assign last_beat = (beat_cnt == {1'b0, len_q});
    assign to_expire = (state == ACCESS) && !bus.PREADY &&
                       (to_cnt == TO_W'(TIMEOUT - 1));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default at the top of every always_comb keeps each path
    // assigned, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cmd_hs) state_nxt = SETUP;
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    state_nxt = (pwrite_q && !last_beat) ? WDATA : RESP;
                end else if (to_expire) begin
                    state_nxt = RESP;
                end
            end
            WDATA: begin
                if (bus.wd_valid) state_nxt = SETUP;
            end
            RESP: begin
                // only multi-beat reads leave RESP with beats outstanding
                if (bus.rsp_ready) state_nxt = rsp_last_q ? IDLE : SETUP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    logic psel;
    logic penable;
    logic cmd_ready;
    logic wd_ready;
    logic rsp_valid;

    always_comb begin
        psel      = 1'b0;
        penable   = 1'b0;
        cmd_ready = 1'b0;
        wd_ready  = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE:    cmd_ready = !PRESET;  // stay closed while reset is held
            SETUP:   psel      = 1'b1;
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            WDATA:   wd_ready  = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.wd_ready    = wd_ready;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.rsp_last    = rsp_last_q;

    assign bus.PSEL    = psel;
    assign bus.PENABLE = penable;
    assign bus.PADDR   = paddr_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PSTRB   = pstrb_q;
    assign bus.PPROT   = 3'b010;

    // -------------------------------------------------------------------------
    // Burst context, counters and response capture
    // -------------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            len_q         <= '0;
            beat_cnt      <= '0;
            to_cnt        <= '0;
            err_acc       <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_last_q    <= 1'b0;
        end else begin
            if (cmd_hs) begin
                paddr_q  <= bus.cmd_addr;
                pwrite_q <= bus.cmd_write;
                pstrb_q  <= bus.cmd_write ? bus.cmd_strb : '0;
                len_q    <= bus.cmd_len;
                beat_cnt <= '0;
                to_cnt   <= '0;
                err_acc  <= 1'b0;
                // reads leave PWDATA alone
                if (bus.cmd_write) pwdata_q <= bus.cmd_wdata;
            end

            if (state == WDATA && bus.wd_valid) begin
                pwdata_q <= bus.wd_data;
            end

            if (state == ACCESS) begin
                if (bus.PREADY) begin
                    beat_cnt      <= beat_cnt + (LEN_W + 1)'(1);
                    to_cnt        <= '0;
                    err_acc       <= err_acc | bus.PSLVERR;
                    rsp_rdata_q   <= pwrite_q ? '0 : bus.PRDATA;
                    // a write reports the error of any beat; a read only its own
                    rsp_err_q     <= pwrite_q ? (err_acc | bus.PSLVERR) : bus.PSLVERR;
                    rsp_timeout_q <= 1'b0;
                    rsp_last_q    <= last_beat;
                end else if (to_expire) begin
                    to_cnt        <= '0;
                    rsp_rdata_q   <= '0;
                    rsp_err_q     <= 1'b1;
                    rsp_timeout_q <= 1'b1;
                    rsp_last_q    <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/apb_fifo_master.md
Name: apb_fifo_master

Overview:
- APB4 requester that drives the APB-attached Sync_FIFO slave. The slave exposes a config register at 0x0000_0000 and a data port at 0x8000_0000.
- Converts a valid/ready command stream plus a write-data stream into APB SETUP/ACCESS transfers.
- Supports fixed-address bursts, so a single command can fill or drain the FIFO data port.
- Returns per-beat read responses and per-burst write responses, and enforces a PREADY timeout.

Parameters:
- ADDR_W, 32, PADDR/cmd_addr width
- DATA_W, 32, PWDATA/PRDATA width
- LEN_W, 8, burst length field width (beats = cmd_len+1)
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort

Ports:
- PCLK  in  1  sole clock, all logic on rising edge
- PRESET  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_addr  in  ADDR_W  address, constant for all beats
- cmd_wdata  in  DATA_W  data for write beat 0
- cmd_strb  in  DATA_W/8  write strobes, all beats
- cmd_len  in  LEN_W  beats minus one
- wd_valid  in  1  data for write beats 1..len
- wd_ready  out  1  write-data accept
- wd_data  in  DATA_W  write beat data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_err  out  1  PSLVERR (read: this beat; write: OR of all beats)
- rsp_timeout  out  1  burst aborted by timeout
- rsp_last  out  1  final response of burst
- PADDR  out  ADDR_W
- PPROT  out  3  constant 3'b010
- PSEL  out  1
- PENABLE  out  1
- PWRITE  out  1
- PWDATA  out  DATA_W
- PSTRB  out  DATA_W/8  forced 0 on reads
- PREADY  in  1
- PRDATA  in  DATA_W
- PSLVERR  in  1  sampled only when PSEL&PENABLE&PREADY

Behaviour:
- Reset (PRESET=1 at an edge): state=IDLE.
  - Outputs 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, cmd_ready, wd_ready, rsp_valid, rsp_err, rsp_timeout, rsp_last, rsp_rdata.
  - PPROT=3'b010.
  - Beat counter, timeout counter and error accumulator cleared.
  - Asserting reset mid-transfer drops PSEL/PENABLE at that edge; the pending response is discarded.
- FSM states: IDLE, SETUP, ACCESS, WDATA, RESP.
- IDLE:
  - cmd_ready=1.
  - On a cmd handshake, latch addr/write/strb/len and PWDATA=cmd_wdata (PWDATA unchanged for reads), then go to SETUP.
- SETUP: PSEL=1, PENABLE=0; PADDR, PWRITE, PWDATA, PSTRB stable. Next state is ACCESS unconditionally.
- ACCESS:
  - PSEL=1, PENABLE=1, all other APB outputs held stable.
  - On PREADY=1 the beat completes. Capture PRDATA/PSLVERR, increment beat counter, clear timeout counter.
  - Minimum 2 cycles per beat with zero wait states.
  - Next state after a completed beat:
    - Read beat → RESP.
    - Write beat, not last → WDATA.
    - Write beat, last → RESP.
  - PSEL/PENABLE deassert the cycle after completion; no back-to-back ACCESS without SETUP.
- Timeout:
  - The counter increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT, drop PSEL/PENABLE and go to RESP with rsp_timeout=1, rsp_err=1, rsp_last=1.
  - Remaining beats are skipped.
- WDATA:
  - wd_ready=1.
  - On wd_valid, latch PWDATA=wd_data and go to SETUP. No APB activity meanwhile.
- RESP:
  - rsp_valid=1 with outputs stable until rsp_ready.
  - On handshake: if more beats (reads), go to SETUP; otherwise go to IDLE.
  - Read beats stall here, so no next SETUP occurs while a response is unconsumed.
  - Write bursts produce exactly one response (rsp_last=1).
  - rsp_last=1 on the final read beat.
- Accumulator: a write error does not abort the burst; the error is accumulated and reported in the single write response.
- Latency: cmd handshake at edge N gives SETUP at N+1, ACCESS at N+2. With zero wait, rsp_valid is seen at N+3.
- Address is never incremented. The beat counter is LEN_W+1 bits wide, so cmd_len=all-ones yields 2^LEN_W beats with no wrap.

Test Plan:
- Config write: cmd write 0x0000_0000, data 0x1, len=0, zero-wait slave → PSEL high exactly 2 cycles, PENABLE high 1 cycle, PSTRB=cmd_strb, rsp_valid at N+3 with rsp_err=0, rsp_last=1.
- Fill burst:
  - Stimulus: write 0x8000_0000, len=7, wd stream with 1-cycle gaps; FIFO model depth 8.
  - Response: 8 SETUP/ACCESS pairs carrying the data in order, one response with rsp_err=0.
  - Repeat with len=8: 9th beat PSLVERR=1 → rsp_err=1.
- Drain burst with backpressure: read 0x8000_0000, len=7, rsp_ready low 3 cycles per beat → no SETUP while rsp_valid=1; 8 responses in FIFO order; only the 8th has rsp_last=1; PSTRB=0 throughout.
- Invalid address: read 0xFFFF_FFFF, slave returns PSLVERR=1 → rsp_err=1, rsp_rdata captured, FSM returns to IDLE with cmd_ready=1.
- Timeout: PREADY held 0, TIMEOUT=16 → PSEL drops after 16 ACCESS cycles; rsp_timeout=1, rsp_err=1, rsp_last=1; the next command proceeds normally.
- Reset mid-ACCESS: PRESET=1 for one edge during beat 3 of a read burst → PSEL=PENABLE=rsp_valid=0 after that edge, cmd_ready=1 the cycle after release, no stale response emitted.
